fifo_reader: RTL and testbench

FIFO_READER -- requirements
Module: fifo_reader

---
 rtl/fifo_pkg.sv | 13 +
 rtl/skid_buf2.sv | 55 +++++
 rtl/fifo_reader.sv | 86 ++++++++
 tb/tb_fifo_reader.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO burst reader: FSM encoding and default widths.
package fifo_pkg;

    localparam int DW_DEFAULT = 8;
    localparam int LW_DEFAULT = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        FLUSH = 2'd2
    } state_t;

endpackage

// File: rtl/skid_buf2.sv
// Two-entry valid/ready buffer; outputs come straight from registers, so out_ready
// never reaches out_valid/out_data combinationally.
module skid_buf2 #(
    parameter int W = 9
) (
    input  logic         rclk,
    input  logic         reset_r,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic [W-1:0] mem [2];
    logic         wr_ptr;
    logic         rd_ptr;
    logic [1:0]   count;
    logic         put;
    logic         take;

    assign out_valid = (count != 2'd0);
    assign out_data  = mem[rd_ptr];
    assign take      = out_valid & out_ready;
    // A slot leaving this cycle may be refilled in the same cycle.
    assign in_ready  = (count != 2'd2) | take;
    assign put       = in_valid & in_ready;

    // NOTE: sequential state uses non-blocking (<=) so every flop samples pre-edge values.
    always_ff @(posedge rclk) begin
        if (reset_r) begin
            // NOTE: the storage is reset too, because out_data must read 0 after reset.
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (put) begin
                mem[wr_ptr] <= in_data;
                wr_ptr      <= ~wr_ptr;
            end
            if (take) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({put, take})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fifo_reader.sv
// Reads a requested number of words from a show-ahead FIFO and streams them
// downstream through a 2-entry buffer, tagging the final word of each burst.
module fifo_reader
    import fifo_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int LW = LW_DEFAULT
) (
    input  logic          rclk,
    input  logic          reset_r,
    input  logic          empty,
    input  logic [DW-1:0] rdata,
    output logic          pop,
    input  logic          start,
    input  logic [LW-1:0] len,
    output logic          busy,
    output logic          done,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          out_last
);

    state_t        state;
    logic [LW-1:0] remaining;
    logic          done_r;
    logic          buf_ready;
    logic          last_word;

    assign last_word = (remaining == LW'(1));
    assign pop = !reset_r && (state == READ) && !empty && (remaining != '0) && buf_ready;
    assign busy = (state != IDLE);
    assign done = done_r;

    skid_buf2 #(
        .W(DW + 1)
    ) u_buf (
        .rclk      (rclk),
        .reset_r   (reset_r),
        .in_valid  (pop),
        .in_data   ({last_word, rdata}),
        .in_ready  (buf_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  ({out_last, out_data})
    );

    always_ff @(posedge rclk) begin
        if (reset_r) begin
            state     <= IDLE;
            remaining <= '0;
            done_r    <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        if (len != '0) begin
                            state     <= READ;
                            remaining <= len;
                        end else begin
                            done_r <= 1'b1;
                        end
                    end
                end
                READ: begin
                    if (pop) begin
                        remaining <= remaining - LW'(1);
                        if (last_word) begin
                            state <= FLUSH;
                        end
                    end
                end
                FLUSH: begin
                    // Burst ends only once the tagged word has left the buffer.
                    if (out_valid && out_ready && out_last) begin
                        state  <= IDLE;
                        done_r <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifo_reader.sv
// Directed bench for fifo_reader: a FIFO model feeds the DUT, expected words go
// into a scoreboard queue that a negedge monitor drains on every transfer.
module tb_fifo_reader;

    logic       rclk;
    logic       reset_r;
    logic       empty;
    logic [7:0] rdata;
    logic       pop;
    logic       start;
    logic [7:0] len;
    logic       busy;
    logic       done;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] out_data;
    logic       out_last;

    logic [7:0] words[$];
    logic [8:0] exp_q[$];
    bit         toggle_mode;
    bit         toggle_ph;
    bit         pop_seen;
    int         pop_cnt;
    int         cyc;
    int         n_checks;
    int         n_fail;

    fifo_reader #(.DW(8), .LW(8)) dut (
        .rclk      (rclk),
        .reset_r   (reset_r),
        .empty     (empty),
        .rdata     (rdata),
        .pop       (pop),
        .start     (start),
        .len       (len),
        .busy      (busy),
        .done      (done),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last)
    );

    always #5 rclk = ~rclk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic drive_fifo();
        empty = toggle_ph || (words.size() == 0);
        rdata = (words.size() != 0) ? words[0] : 8'h00;
    endtask

    // One clock: retire the word popped in the cycle just ended, then present the next.
    task automatic tick();
        @(posedge rclk);
        #1;
        if (pop_seen) begin
            pop_cnt++;
            if (words.size() != 0) void'(words.pop_front());
        end
        toggle_ph = toggle_mode ? !toggle_ph : 1'b0;
        drive_fifo();
        cyc++;
        #1;
    endtask

    task automatic load_words(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) words.push_back(base + 8'(i));
        drive_fifo();
    endtask

    task automatic start_burst(input int l);
        for (int i = 0; i < l; i++) exp_q.push_back({(i == l - 1), words[i]});
        pop_cnt = 0;
        cyc = 0;
        start = 1'b1;
        len = 8'(l);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (!done && n < budget) begin
            tick();
            n++;
        end
        check("done_seen", done, 1);
    endtask

    task automatic monitor();
        bit         hold = 1'b0;
        logic [9:0] held;
        logic [8:0] e;
        forever begin
            @(negedge rclk);
            pop_seen = pop;
            if (empty) check("no_pop_when_empty", pop, 0);
            if (reset_r) check("no_pop_in_reset", pop, 0);
            if (hold && !reset_r) check("hold_stable", {out_valid, out_last, out_data}, held);
            if (!reset_r && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("out_unexpected", out_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("out_word", {out_last, out_data}, e);
                end
            end
            hold = out_valid && !out_ready && !reset_r;
            held = {out_valid, out_last, out_data};
        end
    endtask

    initial begin
        rclk = 1'b0;
        reset_r = 1'b1;
        start = 1'b0;
        len = 8'h00;
        out_ready = 1'b1;
        toggle_mode = 1'b0;
        toggle_ph = 1'b0;
        pop_seen = 1'b0;
        pop_cnt = 0;
        cyc = 0;
        n_checks = 0;
        n_fail = 0;
        drive_fifo();
        fork
            monitor();
        join_none

        tick();
        tick();
        check("rst_outputs", {pop, busy, done, out_valid, out_last, out_data}, 0);
        reset_r = 1'b0;

        // Idle with data available: nothing moves.
        load_words(6, 8'h10);
        for (int i = 0; i < 10; i++) begin
            tick();
            check("idle_quiet", {pop, busy, out_valid}, 0);
        end

        // len=4, continuous flow; two surplus words must stay in the FIFO.
        start_burst(4);
        check("b4_busy_c1", busy, 1);
        check("b4_pop_c1", pop, 1);
        check("b4_noval_c1", out_valid, 0);
        tick();
        check("b4_first_c2", {out_valid, out_last, out_data}, 10'h210);
        wait_done(20);
        check("b4_done_cycle", cyc, 6);
        check("b4_busy_with_done", busy, 0);
        check("b4_pops", pop_cnt, 4);
        check("b4_left", words.size(), 2);
        check("b4_sb_drained", exp_q.size(), 0);
        tick();
        check("b4_done_pulse", done, 0);

        // len=3 with empty toggling every cycle.
        words.delete();
        load_words(4, 8'h20);
        toggle_mode = 1'b1;
        start_burst(3);
        wait_done(40);
        toggle_mode = 1'b0;
        check("tg_pops", pop_cnt, 3);
        check("tg_sb_drained", exp_q.size(), 0);

        // len=5 with downstream stalled: buffer fills after two pops.
        words.delete();
        load_words(5, 8'h30);
        out_ready = 1'b0;
        start_burst(5);
        for (int i = 0; i < 8; i++) tick();
        check("st_pops_held", pop_cnt, 2);
        check("st_pop_low", pop, 0);
        check("st_head", {out_valid, out_last, out_data}, 10'h230);
        out_ready = 1'b1;
        wait_done(30);
        check("st_pops", pop_cnt, 5);
        check("st_sb_drained", exp_q.size(), 0);

        // len=0: immediate done, nothing read.
        words.delete();
        load_words(6, 8'h40);
        start_burst(0);
        check("z_done", done, 1);
        check("z_busy", busy, 0);
        check("z_pops", pop_cnt, 0);
        tick();
        check("z_done_pulse", done, 0);
        check("z_no_pop", pop_cnt, 0);

        // Start while busy is ignored.
        start_burst(3);
        tick();
        start = 1'b1;
        len = 8'd7;
        tick();
        start = 1'b0;
        wait_done(30);
        check("rb_pops", pop_cnt, 3);
        check("rb_left", words.size(), 3);
        check("rb_sb_drained", exp_q.size(), 0);

        // Reset after two of six words.
        words.delete();
        load_words(8, 8'h50);
        start_burst(6);
        for (int i = 0; i < 10 && pop_cnt < 2; i++) tick();
        reset_r = 1'b1;
        tick();
        check("ab_pop_in_reset", pop, 0);
        tick();
        check("ab_outputs", {pop, busy, done, out_valid, out_last, out_data}, 0);
        reset_r = 1'b0;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            tick();
            check("ab_no_done", {done, busy, out_valid}, 0);
        end
        check("ab_pops", pop_cnt, 2);
        start_burst(1);
        wait_done(20);
        check("ab_len1_pops", pop_cnt, 1);
        check("ab_sb_drained", exp_q.size(), 0);

        // Maximum length burst: counter must not wrap.
        words.delete();
        load_words(256, 8'h00);
        start_burst(255);
        wait_done(400);
        check("mx_pops", pop_cnt, 255);
        check("mx_left", words.size(), 1);
        check("mx_sb_drained", exp_q.size(), 0);

        tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
